// File: rtl/req_capture8.sv
// req_capture8: 8-channel synchroniser, debouncer and sticky rising-edge
// capture that feeds an 8-to-3 priority encoder. The consumer returns the
// encoded index with an ack strobe to clear one pending bit per cycle.
//
// Optional feature macro: REQ_CAPTURE8_OVERRUN_EN
//   When defined, adds an 8-bit sticky overrun output that flags a second
//   debounced press on a channel whose previous press was not yet acked.
module req_capture8 #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] raw_in,
    input  logic       ack,
    input  logic [2:0] ack_idx,
    output logic [7:0] pending,
    output logic       any_pending,
    output logic [7:0] stable
`ifdef REQ_CAPTURE8_OVERRUN_EN
    ,
    output logic [7:0] overrun
`endif
);

    // Terminal count: stable flips on the cycle the counter reaches this.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [7:0]       s1_q, s1_d;
    logic [7:0]       s2_q, s2_d;
    logic [7:0]       stable_q, stable_d;
    // Previous debounced level, used only for rising-edge detection.
    logic [7:0]       stable_prev_q, stable_prev_d;
    logic [7:0]       pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];
    logic [7:0]       rise_s;
    logic [7:0]       ack_mask_s;

`ifdef REQ_CAPTURE8_OVERRUN_EN
    logic [7:0]       overrun_q, overrun_d;
`endif

    // Two-flop synchroniser per channel, nothing between the stages.
    always_comb begin
        s1_d = raw_in;
        s2_d = s1_q;
    end

    // Per-channel debounce: count consecutive mismatching cycles, flip at limit.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = {CNT_W{1'b0}};
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = {CNT_W{1'b0}};
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Rising-edge capture into sticky pending; a set beats a coincident ack.
    always_comb begin
        stable_prev_d = stable_q;
        rise_s        = stable_q & ~stable_prev_q;
        if (ack) begin
            ack_mask_s = 8'b0000_0001 << ack_idx;
        end else begin
            ack_mask_s = 8'b0000_0000;
        end
        pending_d = (pending_q & ~ack_mask_s) | rise_s;
    end

`ifdef REQ_CAPTURE8_OVERRUN_EN
    // Overrun flags a new press on a still-pending, non-acked channel.
    always_comb begin
        overrun_d = (overrun_q & ~ack_mask_s) | (rise_s & pending_q & ~ack_mask_s);
    end
`endif

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q          <= 8'h00;
            s2_q          <= 8'h00;
            stable_q      <= 8'h00;
            stable_prev_q <= 8'h00;
            pending_q     <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= {CNT_W{1'b0}};
            end
`ifdef REQ_CAPTURE8_OVERRUN_EN
            overrun_q     <= 8'h00;
`endif
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            pending_q     <= pending_d;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
`ifdef REQ_CAPTURE8_OVERRUN_EN
            overrun_q     <= overrun_d;
`endif
        end
    end

    assign pending     = pending_q;
    assign stable      = stable_q;
    assign any_pending = |pending_q;
`ifdef REQ_CAPTURE8_OVERRUN_EN
    assign overrun     = overrun_q;
`endif

endmodule

// File: tb/tb_req_capture8.sv
// Testbench for req_capture8 with DB_CYCLES=4. Expected pending/stable
// (and overrun when REQ_CAPTURE8_OVERRUN_EN is defined) values are pushed
// with a due edge number when stimulus is driven; a negedge monitor pops
// and compares entries whose edge has arrived.
module tb_req_capture8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] raw_in;
    logic       ack;
    logic [2:0] ack_idx;
    logic [7:0] pending;
    logic       any_pending;
    logic [7:0] stable;
`ifdef REQ_CAPTURE8_OVERRUN_EN
    logic [7:0] overrun;
`endif

    int cyc     = 0;
    int n_check = 0;
    int n_pass  = 0;

    typedef struct {
        int         due;
        string      tag;
        logic [7:0] p;
        logic [7:0] s;
        logic [7:0] o;
    } exp_t;
    exp_t sb_q[$];

    req_capture8 #(.DB_CYCLES(4), .CNT_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw_in      (raw_in),
        .ack         (ack),
        .ack_idx     (ack_idx),
        .pending     (pending),
        .any_pending (any_pending),
        .stable      (stable)
`ifdef REQ_CAPTURE8_OVERRUN_EN
        ,
        .overrun     (overrun)
`endif
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Edge counter: value equals the number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_check++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic exp_at(input int rel, input string tag, input logic [7:0] p,
                          input logic [7:0] s, input logic [7:0] o);
        exp_t e;
        e.due = cyc + rel;
        e.tag = tag;
        e.p   = p;
        e.s   = s;
        e.o   = o;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_ack(input logic [2:0] idx, input logic [7:0] p,
                          input logic [7:0] s, input logic [7:0] o);
        ack     = 1'b1;
        ack_idx = idx;
        exp_at(1, $sformatf("ack%0d", idx), p, s, o);
        tick(1);
        ack     = 1'b0;
    endtask

    // Scoreboard monitor: compare every entry that is due after this edge.
    always @(negedge clk) begin
        for (int k = sb_q.size() - 1; k >= 0; k--) begin
            if (sb_q[k].due == cyc) begin
                check_val({sb_q[k].tag, "_pend"}, 32'(pending), 32'(sb_q[k].p));
                check_val({sb_q[k].tag, "_stab"}, 32'(stable), 32'(sb_q[k].s));
                check_val({sb_q[k].tag, "_any"}, 32'(any_pending), 32'(|sb_q[k].p));
`ifdef REQ_CAPTURE8_OVERRUN_EN
                check_val({sb_q[k].tag, "_ovr"}, 32'(overrun), 32'(sb_q[k].o));
`endif
                sb_q.delete(k);
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        raw_in  = 8'hA5;
        ack     = 1'b0;
        ack_idx = 3'd0;

        // Reset held for three edges with inputs high on A5.
        exp_at(1, "rst1", 8'h00, 8'h00, 8'h00);
        exp_at(2, "rst2", 8'h00, 8'h00, 8'h00);
        exp_at(3, "rst3", 8'h00, 8'h00, 8'h00);
        tick(3);
        rst_n = 1'b1;
        exp_at(5, "rel_pre",  8'h00, 8'h00, 8'h00);
        exp_at(6, "rel_stab", 8'h00, 8'hA5, 8'h00);
        exp_at(7, "rel_pend", 8'hA5, 8'hA5, 8'h00);
        tick(8);

        // Clear the A5 events one channel at a time.
        do_ack(3'd0, 8'hA4, 8'hA5, 8'h00);
        do_ack(3'd2, 8'hA0, 8'hA5, 8'h00);
        do_ack(3'd5, 8'h80, 8'hA5, 8'h00);
        do_ack(3'd7, 8'h00, 8'hA5, 8'h00);

        // Release all lines: falling edges are not captured.
        raw_in = 8'h00;
        exp_at(5, "fall_hold", 8'h00, 8'hA5, 8'h00);
        exp_at(6, "fall",      8'h00, 8'h00, 8'h00);
        tick(8);

        // Three-cycle glitch on ch3 is rejected.
        raw_in = 8'h08;
        exp_at(4, "g3_a", 8'h00, 8'h00, 8'h00);
        exp_at(6, "g3_b", 8'h00, 8'h00, 8'h00);
        exp_at(8, "g3_c", 8'h00, 8'h00, 8'h00);
        tick(3);
        raw_in = 8'h00;
        tick(8);

        // Four-cycle pulse on ch3 passes and is captured.
        raw_in = 8'h08;
        exp_at(5,  "g4_pre",  8'h00, 8'h00, 8'h00);
        exp_at(6,  "g4_stab", 8'h00, 8'h08, 8'h00);
        exp_at(7,  "g4_pend", 8'h08, 8'h08, 8'h00);
        exp_at(9,  "g4_hold", 8'h08, 8'h08, 8'h00);
        exp_at(10, "g4_fall", 8'h08, 8'h00, 8'h00);
        tick(4);
        raw_in = 8'h00;
        tick(8);
        do_ack(3'd3, 8'h00, 8'h00, 8'h00);

        // Clean press on ch5 held steady.
        raw_in = 8'h20;
        exp_at(6,  "cp_stab", 8'h00, 8'h20, 8'h00);
        exp_at(7,  "cp_pend", 8'h20, 8'h20, 8'h00);
        exp_at(12, "cp_hold", 8'h20, 8'h20, 8'h00);
        tick(13);

        // Add ch1 to reach pending=0x22, then ack sequence.
        raw_in = 8'h22;
        exp_at(6, "p1_stab", 8'h20, 8'h22, 8'h00);
        exp_at(7, "p1_pend", 8'h22, 8'h22, 8'h00);
        tick(8);
        do_ack(3'd5, 8'h02, 8'h22, 8'h00);
        do_ack(3'd2, 8'h02, 8'h22, 8'h00);
        do_ack(3'd1, 8'h00, 8'h22, 8'h00);

        // Re-press ch1 so it is pending again.
        raw_in = 8'h20;
        exp_at(6, "r1_rel", 8'h00, 8'h20, 8'h00);
        tick(8);
        raw_in = 8'h22;
        exp_at(7, "r1_press", 8'h02, 8'h22, 8'h00);
        tick(8);
        raw_in = 8'h20;
        exp_at(6, "r2_rel", 8'h02, 8'h20, 8'h00);
        tick(8);

        // Rise on ch1 coincides with ack of ch1 while already pending: set wins.
        raw_in = 8'h22;
        exp_at(6, "co_pre", 8'h02, 8'h22, 8'h00);
        tick(6);
        ack     = 1'b1;
        ack_idx = 3'd1;
        exp_at(1, "co_same", 8'h02, 8'h22, 8'h00);
        tick(1);
        ack = 1'b0;
        tick(2);

        // Rise on ch6 while acking ch1: both take effect.
        raw_in = 8'h62;
        exp_at(6, "c6_pre", 8'h02, 8'h62, 8'h00);
        tick(6);
        ack     = 1'b1;
        ack_idx = 3'd1;
        exp_at(1, "c6_diff", 8'h40, 8'h62, 8'h00);
        tick(1);
        ack = 1'b0;
        tick(2);
        do_ack(3'd6, 8'h00, 8'h62, 8'h00);

        // Press, release, press ch0 without ack: events merge, overrun sets.
        raw_in = 8'h63;
        exp_at(7, "o1_pend", 8'h01, 8'h63, 8'h00);
        tick(8);
        raw_in = 8'h62;
        exp_at(6, "o_rel", 8'h01, 8'h62, 8'h00);
        tick(8);
        raw_in = 8'h63;
        exp_at(6, "o2_pre", 8'h01, 8'h63, 8'h00);
        exp_at(7, "o2",     8'h01, 8'h63, 8'h01);
        tick(8);
        do_ack(3'd0, 8'h00, 8'h63, 8'h00);

        // Reset with ch7 pending and ch2 mid-debounce discards everything.
        raw_in = 8'hE3;
        exp_at(7, "r7_pend", 8'h80, 8'hE3, 8'h00);
        tick(8);
        raw_in = 8'hE7;
        tick(3);
        rst_n = 1'b0;
        exp_at(1, "rst_mid", 8'h00, 8'h00, 8'h00);
        tick(1);
        rst_n = 1'b1;
        exp_at(5, "rr_pre",  8'h00, 8'h00, 8'h00);
        exp_at(6, "rr_stab", 8'h00, 8'hE7, 8'h00);
        exp_at(7, "rr_pend", 8'hE7, 8'hE7, 8'h00);
        tick(9);

        // Every queued expectation must have been consumed.
        tick(2);
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
